// File: rtl/rob_recovery_ctrl_pkg.sv
// Shared types for ROB mispredict recovery: ROB id / PC types and the recovery FSM state.
package rob_recovery_ctrl_pkg;

  localparam int unsigned ROB_N_ENTRIES = 16;
  localparam int unsigned ROB_ID_WIDTH  = 4;
  localparam int unsigned PC_WIDTH      = 32;

  typedef logic [ROB_ID_WIDTH-1:0] rob_id_t;
  typedef logic [PC_WIDTH-1:0]     pc_t;

  typedef enum logic [1:0] {
    RCV_IDLE     = 2'd0,
    RCV_REDIRECT = 2'd1,
    RCV_DRAIN    = 2'd2
  } rcv_state_t;

endpackage

// File: rtl/rob_age_cmp.sv
// Relative ROB age compare: a is older than or equal to b, measured from the current head.
module rob_age_cmp
  import rob_recovery_ctrl_pkg::*;
#(
  parameter int unsigned ID_WIDTH = ROB_ID_WIDTH
) (
  input  logic [ID_WIDTH-1:0] a_id,
  input  logic [ID_WIDTH-1:0] b_id,
  input  logic [ID_WIDTH-1:0] head_id,
  output logic                a_older_or_eq
);

  logic [ID_WIDTH-1:0] a_age;
  logic [ID_WIDTH-1:0] b_age;

  // Wrapping subtraction turns circular ROB ids into a linear distance from the head.
  always_comb begin
    a_age         = a_id - head_id;
    b_age         = b_id - head_id;
    a_older_or_eq = (a_age <= b_age);
  end

endmodule

// File: rtl/rob_recovery_ctrl.sv
// Mispredict recovery sequencer: tracks the oldest mispredicted branch, then flushes,
// redirects fetch and holds dispatch until the pipeline drains.
module rob_recovery_ctrl
  import rob_recovery_ctrl_pkg::*;
#(
  parameter int unsigned ROB_N_ENTRIES = rob_recovery_ctrl_pkg::ROB_N_ENTRIES,
  parameter int unsigned ROB_ID_WIDTH  = rob_recovery_ctrl_pkg::ROB_ID_WIDTH,
  parameter int unsigned PC_WIDTH      = rob_recovery_ctrl_pkg::PC_WIDTH,
  parameter int unsigned DRAIN_CYCLES  = 2
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    head_valid,
  input  logic [ROB_ID_WIDTH-1:0] head_rob_id,
  input  logic [PC_WIDTH-1:0]     head_pc,
  input  logic                    head_reg_ready,
  input  logic                    head_br_mispredict,
  input  logic                    head_ld_mispredict,
  input  logic                    alu_wb_valid,
  input  logic [ROB_ID_WIDTH-1:0] alu_wb_rob_id,
  input  logic                    alu_wb_br_mispredict,
  input  logic [PC_WIDTH-1:0]     alu_wb_br_target,
  output logic                    flush,
  output logic                    redirect_valid,
  output logic [PC_WIDTH-1:0]     redirect_pc,
  input  logic                    redirect_ready,
  output logic                    dispatch_stall
);

  if (ROB_N_ENTRIES != (1 << ROB_ID_WIDTH)) begin : g_bad_depth
    $error("ROB_N_ENTRIES must equal 2**ROB_ID_WIDTH");
  end
  if (DRAIN_CYCLES < 1 || DRAIN_CYCLES > 15) begin : g_bad_drain
    $error("DRAIN_CYCLES must be in 1..15");
  end

  localparam logic [3:0] DrainInit = 4'(DRAIN_CYCLES - 1);

  rcv_state_t state_q, state_d;

  logic                    trk_valid_q;
  logic [ROB_ID_WIDTH-1:0] trk_id_q;
  logic [PC_WIDTH-1:0]     trk_target_q;
  logic [3:0]              drain_cnt_q;
  logic [PC_WIDTH-1:0]     redir_pc_q;
  logic                    flush_q;

  logic trigger;
  logic wb_older_or_eq;
  logic trk_load;

  rob_age_cmp #(
    .ID_WIDTH (ROB_ID_WIDTH)
  ) u_age_cmp (
    .a_id          (alu_wb_rob_id),
    .b_id          (trk_id_q),
    .head_id       (head_rob_id),
    .a_older_or_eq (wb_older_or_eq)
  );

  always_comb begin
    trigger  = (state_q == RCV_IDLE) & head_valid & head_reg_ready &
               (head_br_mispredict | head_ld_mispredict);
    // Writebacks outside IDLE belong to entries the flush is about to squash.
    trk_load = (state_q == RCV_IDLE) & alu_wb_valid & alu_wb_br_mispredict &
               (~trk_valid_q | wb_older_or_eq);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= RCV_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      RCV_IDLE:     if (trigger) state_d = RCV_REDIRECT;
      RCV_REDIRECT: if (redirect_ready) state_d = RCV_DRAIN;
      RCV_DRAIN:    if (drain_cnt_q == 4'd0) state_d = RCV_IDLE;
      default:      state_d = RCV_IDLE;
    endcase
  end

  always_comb begin
    flush          = flush_q;
    redirect_valid = (state_q == RCV_REDIRECT);
    redirect_pc    = redir_pc_q;
    dispatch_stall = (state_q != RCV_IDLE) | trigger;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      trk_valid_q  <= 1'b0;
      trk_id_q     <= '0;
      trk_target_q <= '0;
      drain_cnt_q  <= 4'd0;
      redir_pc_q   <= '0;
      flush_q      <= 1'b0;
    end else begin
      flush_q <= trigger;
      if (trigger) begin
        // A load replays from its own PC, so it wins over any tracked branch target.
        redir_pc_q <= head_ld_mispredict ? head_pc : trk_target_q;
      end
      if (flush_q) begin
        trk_valid_q <= 1'b0;
      end else if (trk_load) begin
        trk_valid_q  <= 1'b1;
        trk_id_q     <= alu_wb_rob_id;
        trk_target_q <= alu_wb_br_target;
      end
      if ((state_q == RCV_REDIRECT) && redirect_ready) begin
        drain_cnt_q <= DrainInit;
      end else if ((state_q == RCV_DRAIN) && (drain_cnt_q != 4'd0)) begin
        drain_cnt_q <= drain_cnt_q - 4'd1;
      end
    end
  end

  // A branch reaching the head must be the one the tracker is holding.
  a_br_tracked : assert property (@(posedge clk) disable iff (rst)
    (trigger && head_br_mispredict && !head_ld_mispredict) |->
      (trk_valid_q && (trk_id_q == head_rob_id)));

endmodule

// File: tb/tb_rob_recovery_ctrl.sv
// Directed bench for rob_recovery_ctrl: reset, branch/load recovery, age wrap, backpressure.
module tb_rob_recovery_ctrl;
  import rob_recovery_ctrl_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        head_valid;
  logic [3:0]  head_rob_id;
  logic [31:0] head_pc;
  logic        head_reg_ready;
  logic        head_br_mispredict;
  logic        head_ld_mispredict;
  logic        alu_wb_valid;
  logic [3:0]  alu_wb_rob_id;
  logic        alu_wb_br_mispredict;
  logic [31:0] alu_wb_br_target;
  logic        flush;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        redirect_ready;
  logic        dispatch_stall;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  rob_recovery_ctrl dut (
    .clk                  (clk),
    .rst                  (rst),
    .head_valid           (head_valid),
    .head_rob_id          (head_rob_id),
    .head_pc              (head_pc),
    .head_reg_ready       (head_reg_ready),
    .head_br_mispredict   (head_br_mispredict),
    .head_ld_mispredict   (head_ld_mispredict),
    .alu_wb_valid         (alu_wb_valid),
    .alu_wb_rob_id        (alu_wb_rob_id),
    .alu_wb_br_mispredict (alu_wb_br_mispredict),
    .alu_wb_br_target     (alu_wb_br_target),
    .flush                (flush),
    .redirect_valid       (redirect_valid),
    .redirect_pc          (redirect_pc),
    .redirect_ready       (redirect_ready),
    .dispatch_stall       (dispatch_stall)
  );

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    head_valid           = 1'b0;
    head_rob_id          = 4'd0;
    head_pc              = 32'd0;
    head_reg_ready       = 1'b0;
    head_br_mispredict   = 1'b0;
    head_ld_mispredict   = 1'b0;
    alu_wb_valid         = 1'b0;
    alu_wb_rob_id        = 4'd0;
    alu_wb_br_mispredict = 1'b0;
    alu_wb_br_target     = 32'd0;
    redirect_ready       = 1'b0;
  endtask

  // One-cycle mispredicted-branch writeback.
  task automatic wb(input logic [3:0] id, input logic [31:0] tgt);
    alu_wb_valid         = 1'b1;
    alu_wb_rob_id        = id;
    alu_wb_br_mispredict = 1'b1;
    alu_wb_br_target     = tgt;
    cyc();
    alu_wb_valid         = 1'b0;
    alu_wb_br_mispredict = 1'b0;
  endtask

  task automatic test_reset();
    idle_inputs();
    rst = 1'b1;
    cyc();
    cyc();
    rst = 1'b0;
    #1;
    checks++;
    if ({flush, redirect_valid, dispatch_stall} !== 3'b000) begin
      errors++;
      $display("FAIL reset_ctrl got %b exp 000", {flush, redirect_valid, dispatch_stall});
    end
    checks++;
    if (redirect_pc !== 32'd0) begin
      errors++;
      $display("FAIL reset_pc got %h exp 0", redirect_pc);
    end
    checks++;
    if (dut.state_q !== RCV_IDLE || dut.trk_valid_q !== 1'b0) begin
      errors++;
      $display("FAIL reset_state got %0d/%b exp IDLE/0", dut.state_q, dut.trk_valid_q);
    end
  endtask

  task automatic test_reset_mid_drain();
    idle_inputs();
    head_valid  = 1'b1;
    head_rob_id = 4'd4;
    wb(4'd4, 32'h0000_0a00);
    head_reg_ready     = 1'b1;
    head_br_mispredict = 1'b1;
    cyc();
    idle_inputs();
    redirect_ready = 1'b1;
    cyc();
    redirect_ready = 1'b0;
    checks++;
    if (dut.state_q !== RCV_DRAIN || dut.drain_cnt_q !== 4'd1) begin
      errors++;
      $display("FAIL middrain_pre got %0d/%0d exp DRAIN/1", dut.state_q, dut.drain_cnt_q);
    end
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    #1;
    checks++;
    if ({flush, redirect_valid, dispatch_stall} !== 3'b000 || redirect_pc !== 32'd0) begin
      errors++;
      $display("FAIL middrain_out got %b pc %h exp 000 pc 0",
               {flush, redirect_valid, dispatch_stall}, redirect_pc);
    end
    checks++;
    if (dut.state_q !== RCV_IDLE || dut.trk_valid_q !== 1'b0) begin
      errors++;
      $display("FAIL middrain_state got %0d/%b exp IDLE/0", dut.state_q, dut.trk_valid_q);
    end
  endtask

  task automatic test_branch();
    idle_inputs();
    head_valid  = 1'b1;
    head_rob_id = 4'd3;
    wb(4'd5, 32'h0000_0400);
    checks++;
    if (dut.trk_valid_q !== 1'b1 || dut.trk_id_q !== 4'd5 || dut.trk_target_q !== 32'h400) begin
      errors++;
      $display("FAIL br_track got %b/%0d/%h exp 1/5/400",
               dut.trk_valid_q, dut.trk_id_q, dut.trk_target_q);
    end
    head_rob_id        = 4'd5;
    head_reg_ready     = 1'b1;
    head_br_mispredict = 1'b1;
    #1;
    checks++;
    if (dispatch_stall !== 1'b1 || flush !== 1'b0 || redirect_valid !== 1'b0) begin
      errors++;
      $display("FAIL br_detect got stall %b flush %b rv %b exp 1 0 0",
               dispatch_stall, flush, redirect_valid);
    end
    cyc();
    idle_inputs();
    #1;
    checks++;
    if (flush !== 1'b1 || redirect_valid !== 1'b1 || redirect_pc !== 32'h400) begin
      errors++;
      $display("FAIL br_redirect got flush %b rv %b pc %h exp 1 1 400",
               flush, redirect_valid, redirect_pc);
    end
    redirect_ready = 1'b1;
    cyc();
    redirect_ready = 1'b0;
    checks++;
    if (flush !== 1'b0 || redirect_valid !== 1'b0 || dispatch_stall !== 1'b1 ||
        dut.trk_valid_q !== 1'b0) begin
      errors++;
      $display("FAIL br_drain1 got flush %b rv %b stall %b trk %b exp 0 0 1 0",
               flush, redirect_valid, dispatch_stall, dut.trk_valid_q);
    end
    cyc();
    checks++;
    if (dispatch_stall !== 1'b1 || dut.state_q !== RCV_DRAIN) begin
      errors++;
      $display("FAIL br_drain2 got stall %b state %0d exp 1 DRAIN", dispatch_stall, dut.state_q);
    end
    cyc();
    checks++;
    if (dispatch_stall !== 1'b0 || dut.state_q !== RCV_IDLE) begin
      errors++;
      $display("FAIL br_idle got stall %b state %0d exp 0 IDLE", dispatch_stall, dut.state_q);
    end
  endtask

  task automatic test_age_wrap();
    idle_inputs();
    head_valid  = 1'b1;
    head_rob_id = 4'd14;
    wb(4'd1, 32'h0000_0100);
    wb(4'd15, 32'h0000_0200);
    checks++;
    if (dut.trk_valid_q !== 1'b1 || dut.trk_id_q !== 4'd15 || dut.trk_target_q !== 32'h200) begin
      errors++;
      $display("FAIL wrap_older got %b/%0d/%h exp 1/15/200",
               dut.trk_valid_q, dut.trk_id_q, dut.trk_target_q);
    end
    wb(4'd2, 32'h0000_0300);
    checks++;
    if (dut.trk_id_q !== 4'd15 || dut.trk_target_q !== 32'h200) begin
      errors++;
      $display("FAIL wrap_younger got %0d/%h exp 15/200", dut.trk_id_q, dut.trk_target_q);
    end
    wb(4'd15, 32'h0000_0380);
    checks++;
    if (dut.trk_id_q !== 4'd15 || dut.trk_target_q !== 32'h380) begin
      errors++;
      $display("FAIL wrap_equal got %0d/%h exp 15/380", dut.trk_id_q, dut.trk_target_q);
    end
  endtask

  task automatic test_load_priority();
    idle_inputs();
    head_valid  = 1'b1;
    head_rob_id = 4'd7;
    wb(4'd7, 32'h0000_0900);
    checks++;
    if (dut.trk_id_q !== 4'd7 || dut.trk_target_q !== 32'h900) begin
      errors++;
      $display("FAIL ld_track got %0d/%h exp 7/900", dut.trk_id_q, dut.trk_target_q);
    end
    head_pc            = 32'h0000_0080;
    head_reg_ready     = 1'b1;
    head_br_mispredict = 1'b1;
    head_ld_mispredict = 1'b1;
    cyc();
    idle_inputs();
    #1;
    checks++;
    if (redirect_valid !== 1'b1 || redirect_pc !== 32'h80 || flush !== 1'b1) begin
      errors++;
      $display("FAIL ld_redirect got rv %b pc %h flush %b exp 1 80 1",
               redirect_valid, redirect_pc, flush);
    end
    redirect_ready = 1'b1;
    cyc();
    redirect_ready = 1'b0;
    cyc();
    cyc();
    checks++;
    if (dut.state_q !== RCV_IDLE || dispatch_stall !== 1'b0) begin
      errors++;
      $display("FAIL ld_idle got state %0d stall %b exp IDLE 0", dut.state_q, dispatch_stall);
    end
  endtask

  task automatic test_backpressure();
    int flushes;
    idle_inputs();
    head_valid     = 1'b1;
    head_rob_id    = 4'd9;
    redirect_ready = 1'b1;
    wb(4'd9, 32'h1234_5678);
    checks++;
    if (dut.state_q !== RCV_IDLE || redirect_valid !== 1'b0) begin
      errors++;
      $display("FAIL bp_idle_ready got state %0d rv %b exp IDLE 0", dut.state_q, redirect_valid);
    end
    redirect_ready     = 1'b0;
    head_reg_ready     = 1'b1;
    head_br_mispredict = 1'b1;
    cyc();
    idle_inputs();
    flushes = 0;
    for (int i = 0; i < 4; i++) begin
      #1;
      if (flush === 1'b1) flushes++;
      checks++;
      if (redirect_valid !== 1'b1 || redirect_pc !== 32'h1234_5678) begin
        errors++;
        $display("FAIL bp_hold[%0d] got rv %b pc %h exp 1 12345678", i, redirect_valid, redirect_pc);
      end
      redirect_ready = (i == 3);
      cyc();
    end
    redirect_ready = 1'b0;
    checks++;
    if (flushes !== 1) begin
      errors++;
      $display("FAIL bp_flush_count got %0d exp 1", flushes);
    end
    checks++;
    if (dut.state_q !== RCV_DRAIN || redirect_valid !== 1'b0 || dispatch_stall !== 1'b1) begin
      errors++;
      $display("FAIL bp_drain1 got state %0d rv %b stall %b exp DRAIN 0 1",
               dut.state_q, redirect_valid, dispatch_stall);
    end
    cyc();
    checks++;
    if (dut.state_q !== RCV_DRAIN || dispatch_stall !== 1'b1) begin
      errors++;
      $display("FAIL bp_drain2 got state %0d stall %b exp DRAIN 1", dut.state_q, dispatch_stall);
    end
    cyc();
    checks++;
    if (dut.state_q !== RCV_IDLE || dispatch_stall !== 1'b0) begin
      errors++;
      $display("FAIL bp_idle got state %0d stall %b exp IDLE 0", dut.state_q, dispatch_stall);
    end
  endtask

  task automatic test_flush_window();
    idle_inputs();
    head_valid  = 1'b1;
    head_rob_id = 4'd2;
    wb(4'd2, 32'h0000_2000);
    head_reg_ready     = 1'b1;
    head_br_mispredict = 1'b1;
    cyc();
    // Head still flagged and a fresh mispredict writeback: both must be ignored.
    alu_wb_valid         = 1'b1;
    alu_wb_rob_id        = 4'd3;
    alu_wb_br_mispredict = 1'b1;
    alu_wb_br_target     = 32'h0000_dead;
    #1;
    checks++;
    if (flush !== 1'b1 || redirect_pc !== 32'h2000 || dispatch_stall !== 1'b1) begin
      errors++;
      $display("FAIL fw_redirect got flush %b pc %h stall %b exp 1 2000 1",
               flush, redirect_pc, dispatch_stall);
    end
    cyc();
    redirect_ready = 1'b1;
    checks++;
    if (flush !== 1'b0 || redirect_valid !== 1'b1) begin
      errors++;
      $display("FAIL fw_no_refire got flush %b rv %b exp 0 1", flush, redirect_valid);
    end
    cyc();
    redirect_ready     = 1'b0;
    head_valid         = 1'b0;
    head_reg_ready     = 1'b0;
    head_br_mispredict = 1'b0;
    checks++;
    if (dut.trk_valid_q !== 1'b0) begin
      errors++;
      $display("FAIL fw_trk_drain got %b exp 0", dut.trk_valid_q);
    end
    cyc();
    alu_wb_valid         = 1'b0;
    alu_wb_br_mispredict = 1'b0;
    cyc();
    checks++;
    if (dut.state_q !== RCV_IDLE || dut.trk_valid_q !== 1'b0) begin
      errors++;
      $display("FAIL fw_trk_idle got state %0d trk %b exp IDLE 0", dut.state_q, dut.trk_valid_q);
    end
  endtask

  initial begin
    test_reset();
    test_reset_mid_drain();
    test_branch();
    test_age_wrap();
    test_load_priority();
    test_backpressure();
    test_flush_window();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
